ex_operand_stage: RTL and testbench
===================================

Name: ex_operand_stage

Overview:
- ID/EX pipeline register and operand-select stage that feeds the 64-bit ALU in the execute stage.
- Registers decoded operands, immediate and control from decode.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Drives ALU inputs a, b and the 4-bit ALU control; raises a load-use stall request back to decode.

Parameters:
N, 64, datapath width of operands/results
REGW, 5, register index width (X0..X31, X31 = XZR)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
id_valid  input  1  decode slot holds a real instruction
id_rd1, id_rd2  input  N  register file read data (Rn, Rm/Rt)
id_imm  input  N  sign-extended immediate
id_rn, id_rm, id_rdst  input  REGW  source/destination indices
id_alu_src  input  1  0: b = Rm operand, 1: b = immediate
id_alu_ctrl  input  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 pass-b, 1100 NOR
id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch  input  1 each  control
stall  input  1  hold register contents
flush  input  1  squash into a bubble
exmem_reg_write  input  1  EX/MEM writes a register
exmem_rd  input  REGW  EX/MEM destination
exmem_result  input  N  EX/MEM ALU result
memwb_reg_write  input  1  MEM/WB writes a register
memwb_rd  input  REGW  MEM/WB destination
memwb_result  input  N  MEM/WB write-back value
alu_a, alu_b  output  N  ALU operands
alu_ctrl  output  4  registered ALU control
ex_store_data  output  N  forwarded Rt value for stores
ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch  output  1 each  registered control
ex_rdst  output  REGW  registered destination
ex_imm  output  N  registered immediate (branch target calc)
load_use_stall  output  1  request decode/fetch stall

Behaviour:
- Register update on rising clk; priority reset > flush > stall > load.
- reset: all registered fields 0, ex_valid=0; outputs then alu_a=alu_b=0, alu_ctrl=0000, ex_store_data=0, load_use_stall=0.
- flush: bubble; ex_valid and all control bits 0, ex_rdst=31, data fields don't-care (cleared to 0). flush overrides simultaneous stall.
- stall (no flush): every registered field holds.
- Load: id_* captured. If id_valid=0, control bits captured as 0.
- Latency: one cycle from id_* to ex_* and the ALU inputs.
- Forwarding, combinational on registered operands, per source (Rn and Rm independently):
  - Use EX/MEM if exmem_reg_write=1, exmem_rd==src and src!=31.
  - Otherwise use MEM/WB under the same conditions.
  - Otherwise use the registered read data.
  - EX/MEM wins when both match.
- Source index 31 (XZR) is never forwarded; the operand passes as registered (regfile supplies 0).
- alu_a = forwarded Rn.
- alu_b = registered imm if alu_src=1, else forwarded Rm.
- ex_store_data = forwarded Rm regardless of alu_src.
- Forwarding and bubbles: forwarding is still computed while ex_valid=0; harmless because control is zeroed.
- load_use_stall = ex_valid & ex_mem_read & ex_rdst!=31 & id_valid & (ex_rdst==id_rn | ex_rdst==id_rm). Combinational.
- The pipeline controller turns load_use_stall into stall of IF/ID and flush of this stage; this block does not self-insert the bubble.
- Widths: no arithmetic here; all muxes are full N bits, no truncation.

Decomposition:
- Shared package cpu_pkg:
  - alu_op_t enum (AND=4'b0000, OR=4'b0001, ADD=4'b0010, SUB=4'b0110, PASSB=4'b0111, NOR=4'b1100)
  - XZR constant 5'd31
  - ex_ctrl_t struct (reg_write, mem_read, mem_write, mem_to_reg, branch)
- One sub-module: forward_unit (pure combinational).
  - Inputs: rn, rm, exmem/memwb rd, reg_write.
  - Outputs: 2-bit selects fwd_a, fwd_b (00 reg, 10 EX/MEM, 01 MEM/WB).
  - Instantiated once, shared by both operands.

Test Plan:
- Reset held 2 cycles with id_* random -> all outputs 0, ex_valid=0, alu_ctrl=0000; first load after release -> ex_* equals prior-cycle id_* after 1 clk.
- ADD X1,X2,X3 then SUB X4,X1,X5: exmem_rd=1, exmem_reg_write=1, exmem_result=0x10; id_rd1 stale 0x5 -> alu_a=0x10, alu_ctrl=0110.
- Double hazard: exmem_rd=memwb_rd=2, results 0xAA / 0xBB, src Rm=2, alu_src=0 -> alu_b=0xAA. With alu_src=1, imm=0x7 -> alu_b=0x7 and ex_store_data=0xAA.
- XZR: exmem_rd=31, exmem_reg_write=1, result 0xFF, src Rn=31, id_rd1=0 -> alu_a=0.
- LDUR X9 in EX (ex_mem_read=1, ex_rdst=9), decode id_rn=9, id_valid=1 -> load_use_stall=1. Same with ex_rdst=31 or ex_valid=0 -> 0.
- stall=1 for 3 cycles with changing id_* -> ex_* constant. stall=1 and flush=1 together -> bubble (ex_valid=0, controls 0, ex_rdst=31).

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: types and constants shared by the execute-side pipeline blocks.
//   alu_op_t  - 4-bit ALU control encodings
//   XZR       - index of the zero register (never a forwarding source)
//   ex_ctrl_t - control bits carried from decode into execute
//   FWD_*     - operand select codes produced by forward_unit
package cpu_pkg;

    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000,
        ALU_OR    = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_SUB   = 4'b0110,
        ALU_PASSB = 4'b0111,
        ALU_NOR   = 4'b1100
    } alu_op_t;

    localparam logic [4:0] XZR = 5'd31;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic branch;
    } ex_ctrl_t;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

endpackage

// File: rtl/ex_operand_stage_forward_unit.sv
// forward_unit: combinational RAW-hazard operand select for both ALU sources.
//   rn, rm                          - source register indices held in ID/EX
//   exmem_rd, exmem_reg_write       - destination/write enable of the EX/MEM instruction
//   memwb_rd, memwb_reg_write       - destination/write enable of the MEM/WB instruction
//   fwd_a, fwd_b                    - select for Rn / Rm: FWD_REG, FWD_EXMEM or FWD_MEMWB
module forward_unit
    import cpu_pkg::*;
#(
    parameter int REGW = 5
) (
    input  logic [REGW-1:0] rn,
    input  logic [REGW-1:0] rm,
    input  logic [REGW-1:0] exmem_rd,
    input  logic            exmem_reg_write,
    input  logic [REGW-1:0] memwb_rd,
    input  logic            memwb_reg_write,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b
);

    // EX/MEM is checked first: it holds the younger result, so it must win
    // when both older instructions target the same register. XZR reads as
    // zero whatever anyone "writes" to it, so it is never a forwarding match.
    function automatic logic [1:0] pick(input logic [REGW-1:0] src);
        logic [1:0] sel;
        sel = FWD_REG;
        if (src != XZR) begin
            if (exmem_reg_write && (exmem_rd == src)) begin
                sel = FWD_EXMEM;
            end else if (memwb_reg_write && (memwb_rd == src)) begin
                sel = FWD_MEMWB;
            end
        end
        return sel;
    endfunction

    always_comb begin
        fwd_a = pick(rn);
        fwd_b = pick(rm);
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register plus ALU operand selection.
//   id_*            - decoded instruction presented by decode (captured on load)
//   stall / flush   - pipeline controller: hold this register / squash it to a bubble
//   exmem_*, memwb_* - older in-flight results available for forwarding
//   alu_a, alu_b, alu_ctrl - ALU inputs for the instruction now in execute
//   ex_store_data   - forwarded Rt for stores
//   ex_*            - registered control, destination and immediate
//   load_use_stall  - load in execute feeds the instruction in decode
//
// Register update priority on each rising edge: reset > flush > stall > load.
// flush wins over a simultaneous stall so the controller can hold IF/ID and
// inject a bubble here in the same cycle.
module ex_operand_stage
    import cpu_pkg::*;
#(
    parameter int N    = 64,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [N-1:0]    id_rd1,
    input  logic [N-1:0]    id_rd2,
    input  logic [N-1:0]    id_imm,
    input  logic [REGW-1:0] id_rn,
    input  logic [REGW-1:0] id_rm,
    input  logic [REGW-1:0] id_rdst,
    input  logic            id_alu_src,
    input  logic [3:0]      id_alu_ctrl,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_mem_to_reg,
    input  logic            id_branch,
    input  logic            stall,
    input  logic            flush,
    input  logic            exmem_reg_write,
    input  logic [REGW-1:0] exmem_rd,
    input  logic [N-1:0]    exmem_result,
    input  logic            memwb_reg_write,
    input  logic [REGW-1:0] memwb_rd,
    input  logic [N-1:0]    memwb_result,
    output logic [N-1:0]    alu_a,
    output logic [N-1:0]    alu_b,
    output logic [3:0]      alu_ctrl,
    output logic [N-1:0]    ex_store_data,
    output logic            ex_valid,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_mem_to_reg,
    output logic            ex_branch,
    output logic [REGW-1:0] ex_rdst,
    output logic [N-1:0]    ex_imm,
    output logic            load_use_stall
);

    ex_ctrl_t        id_ctrl;
    ex_ctrl_t        ctrl_q;
    logic [N-1:0]    rd1_q;
    logic [N-1:0]    rd2_q;
    logic [REGW-1:0] rn_q;
    logic [REGW-1:0] rm_q;
    logic            alu_src_q;
    logic [1:0]      fwd_a;
    logic [1:0]      fwd_b;
    logic [N-1:0]    opnd_a;
    logic [N-1:0]    opnd_b;

    assign id_ctrl = '{reg_write:  id_reg_write,
                       mem_read:   id_mem_read,
                       mem_write:  id_mem_write,
                       mem_to_reg: id_mem_to_reg,
                       branch:     id_branch};

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid  <= 1'b0;
            ctrl_q    <= '0;
            alu_ctrl  <= ALU_AND;
            alu_src_q <= 1'b0;
            rd1_q     <= '0;
            rd2_q     <= '0;
            ex_imm    <= '0;
            rn_q      <= '0;
            rm_q      <= '0;
            ex_rdst   <= '0;
        end else if (flush) begin
            // Bubble: destination parked on XZR so nothing downstream can match it.
            ex_valid  <= 1'b0;
            ctrl_q    <= '0;
            alu_ctrl  <= ALU_AND;
            alu_src_q <= 1'b0;
            rd1_q     <= '0;
            rd2_q     <= '0;
            ex_imm    <= '0;
            rn_q      <= '0;
            rm_q      <= '0;
            ex_rdst   <= XZR;
        end else if (!stall) begin
            ex_valid  <= id_valid;
            ctrl_q    <= id_valid ? id_ctrl : '0;
            alu_ctrl  <= id_alu_ctrl;
            alu_src_q <= id_alu_src;
            rd1_q     <= id_rd1;
            rd2_q     <= id_rd2;
            ex_imm    <= id_imm;
            rn_q      <= id_rn;
            rm_q      <= id_rm;
            ex_rdst   <= id_rdst;
        end
    end

    forward_unit #(.REGW(REGW)) u_fwd (
        .rn              (rn_q),
        .rm              (rm_q),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b)
    );

    always_comb begin
        case (fwd_a)
            FWD_EXMEM: opnd_a = exmem_result;
            FWD_MEMWB: opnd_a = memwb_result;
            default:   opnd_a = rd1_q;
        endcase
        case (fwd_b)
            FWD_EXMEM: opnd_b = exmem_result;
            FWD_MEMWB: opnd_b = memwb_result;
            default:   opnd_b = rd2_q;
        endcase
    end

    assign alu_a         = opnd_a;
    assign alu_b         = alu_src_q ? ex_imm : opnd_b;
    assign ex_store_data = opnd_b;

    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign ex_branch     = ctrl_q.branch;

    // A load's data only exists after MEM, so a dependent instruction in
    // decode cannot be satisfied by forwarding next cycle.
    assign load_use_stall = ex_valid && ctrl_q.mem_read && (ex_rdst != XZR) && id_valid
                            && ((ex_rdst == id_rn) || (ex_rdst == id_rm));

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;
    localparam int N    = 64;
    localparam int REGW = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic            id_valid;
    logic [N-1:0]    id_rd1, id_rd2, id_imm;
    logic [REGW-1:0] id_rn, id_rm, id_rdst;
    logic            id_alu_src;
    logic [3:0]      id_alu_ctrl;
    logic            id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch;
    logic            stall, flush;
    logic            exmem_reg_write, memwb_reg_write;
    logic [REGW-1:0] exmem_rd, memwb_rd;
    logic [N-1:0]    exmem_result, memwb_result;
    logic [N-1:0]    alu_a, alu_b, ex_store_data, ex_imm;
    logic [3:0]      alu_ctrl;
    logic            ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch;
    logic [REGW-1:0] ex_rdst;
    logic            load_use_stall;

    ex_operand_stage #(.N(N), .REGW(REGW)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rn(id_rn), .id_rm(id_rm), .id_rdst(id_rdst),
        .id_alu_src(id_alu_src), .id_alu_ctrl(id_alu_ctrl),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
        .stall(stall), .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .ex_store_data(ex_store_data),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
        .ex_rdst(ex_rdst), .ex_imm(ex_imm), .load_use_stall(load_use_stall)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [N-1:0] exp_q[$];

    task automatic check_val(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // State of the instruction currently sitting in execute.
    logic            m_valid, m_rw, m_mr, m_mw, m_m2r, m_br, m_src, m_op_known;
    logic [3:0]      m_op;
    logic [N-1:0]    m_rd1, m_rd2, m_imm;
    logic [REGW-1:0] m_rn, m_rm, m_rdst;

    always @(posedge clk) begin
        if (reset || flush) begin
            m_valid <= 0; m_rw <= 0; m_mr <= 0; m_mw <= 0; m_m2r <= 0; m_br <= 0;
            m_src <= 0; m_op <= 4'h0; m_op_known <= 1;
            m_rd1 <= 0; m_rd2 <= 0; m_imm <= 0; m_rn <= 0; m_rm <= 0;
            m_rdst <= reset ? 5'd0 : 5'd31;
        end else if (!stall) begin
            m_valid <= id_valid;
            m_rw  <= id_valid & id_reg_write;
            m_mr  <= id_valid & id_mem_read;
            m_mw  <= id_valid & id_mem_write;
            m_m2r <= id_valid & id_mem_to_reg;
            m_br  <= id_valid & id_branch;
            m_src <= id_alu_src; m_op <= id_alu_ctrl; m_op_known <= id_valid;
            m_rd1 <= id_rd1; m_rd2 <= id_rd2; m_imm <= id_imm;
            m_rn <= id_rn; m_rm <= id_rm; m_rdst <= id_rdst;
        end
    end

    // Value a source register really has right now: newest producer wins, X31 is constant.
    function automatic logic [N-1:0] operand(input logic [REGW-1:0] src, input logic [N-1:0] regval);
        if (src == 5'd31) return regval;
        if (exmem_reg_write && exmem_rd == src) return exmem_result;
        if (memwb_reg_write && memwb_rd == src) return memwb_result;
        return regval;
    endfunction

    logic cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            #2;
            check_val("alu_a", alu_a, operand(m_rn, m_rd1));
            check_val("alu_b", alu_b, m_src ? m_imm : operand(m_rm, m_rd2));
            check_val("store_data", ex_store_data, operand(m_rm, m_rd2));
            if (m_op_known) check_val("alu_ctrl", 64'(alu_ctrl), 64'(m_op));
            check_val("ex_valid", 64'(ex_valid), 64'(m_valid));
            check_val("ctrl", 64'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch}),
                      64'({m_rw, m_mr, m_mw, m_m2r, m_br}));
            check_val("ex_rdst", 64'(ex_rdst), 64'(m_rdst));
            check_val("ex_imm", ex_imm, m_imm);
            check_val("load_use_stall", 64'(load_use_stall),
                      64'(m_valid && m_mr && m_rdst != 5'd31 && id_valid && (m_rdst == id_rn || m_rdst == id_rm)));
        end
    end

    // ---------------- driver tasks ----------------
    logic [3:0] ops[6] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC};

    function automatic logic [REGW-1:0] rnd_idx();
        int r;
        r = $urandom_range(0, 7);
        return (r == 7) ? 5'd31 : 5'(r);
    endfunction

    task automatic drive_random_id();
        id_valid = 1'($urandom_range(0, 3) != 0);
        id_rd1 = {$urandom, $urandom}; id_rd2 = {$urandom, $urandom}; id_imm = {$urandom, $urandom};
        id_rn = rnd_idx(); id_rm = rnd_idx(); id_rdst = rnd_idx();
        id_alu_src = 1'($urandom_range(0, 1));
        id_alu_ctrl = ops[$urandom_range(0, 5)];
        {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch} = 5'($urandom);
    endtask

    task automatic drive_random_fwd();
        exmem_reg_write = 1'($urandom_range(0, 1)); exmem_rd = rnd_idx(); exmem_result = {$urandom, $urandom};
        memwb_reg_write = 1'($urandom_range(0, 1)); memwb_rd = rnd_idx(); memwb_result = {$urandom, $urandom};
    endtask

    task automatic drive_instr(input logic [REGW-1:0] rn, input logic [REGW-1:0] rm, input logic [REGW-1:0] rd,
                               input logic [N-1:0] rd1, input logic [N-1:0] rd2, input logic [N-1:0] imm,
                               input logic src, input logic [3:0] op, input logic rw, input logic mr);
        id_valid = 1; id_rn = rn; id_rm = rm; id_rdst = rd;
        id_rd1 = rd1; id_rd2 = rd2; id_imm = imm; id_alu_src = src; id_alu_ctrl = op;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = 0; id_mem_to_reg = mr; id_branch = 0;
    endtask

    task automatic no_fwd();
        exmem_reg_write = 0; memwb_reg_write = 0;
        exmem_rd = 0; memwb_rd = 0; exmem_result = 0; memwb_result = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1; stall = 0; flush = 0;
        no_fwd();
        drive_random_id();
        @(negedge clk); drive_random_id();
        @(negedge clk);
        cmp_en = 1;
        #1;
        // reset state
        check_val("rst_alu_a", alu_a, 0);
        check_val("rst_alu_b", alu_b, 0);
        check_val("rst_alu_ctrl", 64'(alu_ctrl), 0);
        check_val("rst_store", ex_store_data, 0);
        check_val("rst_valid", 64'(ex_valid), 0);
        check_val("rst_lus", 64'(load_use_stall), 0);

        // ADD X1,X2,X3 captured one clock after release
        reset = 0;
        drive_instr(5'd2, 5'd3, 5'd1, 64'h2, 64'h3, 64'h1234_5678_9abc_def0, 0, 4'b0010, 1, 0);
        exp_q.push_back(64'h1);
        exp_q.push_back(64'h1234_5678_9abc_def0);
        @(negedge clk); #1;
        check_val("add_valid", 64'(ex_valid), 1);
        check_val("add_ctrl", 64'(alu_ctrl), 64'h2);
        check_val("add_a", alu_a, 64'h2);
        check_val("add_b", alu_b, 64'h3);
        check_val("add_rdst", 64'(ex_rdst), exp_q.pop_front());
        check_val("add_imm", ex_imm, exp_q.pop_front());

        // SUB X4,X1,X5 with X1 produced by the instruction now in EX/MEM
        drive_instr(5'd1, 5'd5, 5'd4, 64'h5, 64'h55, 64'h0, 0, 4'b0110, 1, 0);
        @(negedge clk);
        exmem_reg_write = 1; exmem_rd = 1; exmem_result = 64'h10;
        #1;
        check_val("sub_fwd_a", alu_a, 64'h10);
        check_val("sub_ctrl", 64'(alu_ctrl), 64'h6);
        check_val("sub_b", alu_b, 64'h55);

        // double hazard on Rm: EX/MEM beats MEM/WB
        drive_instr(5'd6, 5'd2, 5'd7, 64'h66, 64'h22, 64'h7, 0, 4'b0010, 1, 0);
        @(negedge clk);
        exmem_reg_write = 1; exmem_rd = 2; exmem_result = 64'hAA;
        memwb_reg_write = 1; memwb_rd = 2; memwb_result = 64'hBB;
        #1;
        check_val("dbl_b", alu_b, 64'hAA);
        check_val("dbl_store", ex_store_data, 64'hAA);
        drive_instr(5'd6, 5'd2, 5'd7, 64'h66, 64'h33, 64'h7, 1, 4'b0010, 1, 0);
        @(negedge clk); #1;
        check_val("imm_b", alu_b, 64'h7);
        check_val("imm_store", ex_store_data, 64'hAA);

        // XZR source is never forwarded
        drive_instr(5'd31, 5'd3, 5'd8, 64'h0, 64'h3, 64'h0, 0, 4'b0010, 1, 0);
        @(negedge clk);
        no_fwd();
        exmem_reg_write = 1; exmem_rd = 31; exmem_result = 64'hFF;
        memwb_reg_write = 1; memwb_rd = 31; memwb_result = 64'hEE;
        #1;
        check_val("xzr_a", alu_a, 64'h0);

        // load-use detection
        no_fwd();
        drive_instr(5'd1, 5'd2, 5'd9, 64'h0, 64'h0, 64'h8, 1, 4'b0010, 1, 1);
        @(negedge clk);
        drive_instr(5'd9, 5'd0, 5'd10, 64'h0, 64'h0, 64'h0, 0, 4'b0010, 1, 0);
        #1; check_val("lu_rn", 64'(load_use_stall), 1);
        id_rn = 0; id_rm = 9;
        #1; check_val("lu_rm", 64'(load_use_stall), 1);
        id_valid = 0;
        #1; check_val("lu_idinv", 64'(load_use_stall), 0);
        drive_instr(5'd1, 5'd2, 5'd31, 64'h0, 64'h0, 64'h8, 1, 4'b0010, 1, 1);
        @(negedge clk);
        drive_instr(5'd31, 5'd31, 5'd10, 64'h0, 64'h0, 64'h0, 0, 4'b0010, 1, 0);
        #1; check_val("lu_xzr", 64'(load_use_stall), 0);
        drive_instr(5'd1, 5'd2, 5'd9, 64'h0, 64'h0, 64'h8, 1, 4'b0010, 1, 1);
        id_valid = 0;
        @(negedge clk);
        drive_instr(5'd9, 5'd9, 5'd10, 64'h0, 64'h0, 64'h0, 0, 4'b0010, 1, 0);
        #1; check_val("lu_exinv", 64'(load_use_stall), 0);

        // stall holds, stall+flush squashes
        drive_instr(5'd3, 5'd4, 5'd12, 64'h1, 64'h2, 64'h1234, 0, 4'b0001, 1, 0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            #1;
            check_val("stall_rdst", 64'(ex_rdst), 64'd12);
            check_val("stall_imm", ex_imm, 64'h1234);
            check_val("stall_ctrl", 64'(alu_ctrl), 64'h1);
            check_val("stall_rw", 64'(ex_reg_write), 1);
            stall = 1;
            drive_random_id();
            if (i < 3) @(negedge clk);
        end
        flush = 1;
        @(negedge clk); #1;
        check_val("flush_valid", 64'(ex_valid), 0);
        check_val("flush_rdst", 64'(ex_rdst), 64'd31);
        check_val("flush_ctrl", 64'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch}), 0);
        stall = 0; flush = 0;

        // randomized phase, checked every cycle by the compare process
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            reset = 1'($urandom_range(0, 63) == 0);
            flush = 1'($urandom_range(0, 7) == 0);
            stall = 1'($urandom_range(0, 4) == 0);
            drive_random_id();
            drive_random_fwd();
        end
        @(negedge clk);
        reset = 0; stall = 0; flush = 0;
        repeat (2) @(negedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
